// File: rtl/strobed_serial_transmitter.sv
// strobed_serial_transmitter: serialises a word onto a data/enable pair with setup, strobe and hold phases per bit
module strobed_serial_transmitter #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_PERIOD = 4,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         parallelIn,
    output logic                          busy,
    output logic                          done,
    output logic                          data,
    output logic                          notdata,
    output logic                          enable,
    output logic [$clog2(DATA_WIDTH)-1:0] bitIndex
);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam int PW = $clog2(BIT_PERIOD);
    localparam logic [IW-1:0] FIRST = MSB_FIRST ? IW'(DATA_WIDTH - 1) : '0;
    localparam logic [IW-1:0] LAST = MSB_FIRST ? '0 : IW'(DATA_WIDTH - 1);
    localparam logic [PW-1:0] HOLD = PW'(BIT_PERIOD - 1);
    localparam logic [PW-1:0] STROBE_END = PW'(BIT_PERIOD - 2);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t                state_q;
    logic [PW-1:0]         phase_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [IW-1:0]         idx_d;
    always_comb begin
        idx_d = MSB_FIRST ? bitIndex - 1'b1 : bitIndex + 1'b1;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            word_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data     <= 1'b0;
            notdata  <= 1'b1;
            enable   <= 1'b0;
            bitIndex <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q  <= SEND;
                    phase_q  <= '0;
                    word_q   <= parallelIn;
                    busy     <= 1'b1;
                    data     <= parallelIn[FIRST];
                    notdata  <= ~parallelIn[FIRST];
                    bitIndex <= FIRST;
                end
                SEND: if (phase_q != HOLD) begin
                    phase_q <= phase_q + 1'b1;
                    enable  <= phase_q < STROBE_END;
                end else if (bitIndex == LAST) begin
                    state_q <= DONE;
                    done    <= 1'b1;
                end else begin
                    phase_q  <= '0;
                    bitIndex <= idx_d;
                    data     <= word_q[idx_d];
                    notdata  <= ~word_q[idx_d];
                end
                DONE: begin
                    state_q  <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    data     <= 1'b0;
                    notdata  <= 1'b1;
                    bitIndex <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/strobed_serial_transmitter.md
Name: strobed_serial_transmitter

Overview:
Serialises a parallel word onto a data/enable pair that drives gated D latches (or a chain of them), one bit at a time. Each bit is presented with a setup phase, an enable strobe, and a hold phase, so `data` is never changing while `enable` is high. It sits on the write side of the lab's latch and register experiments and replaces hand-toggled switches as the stimulus source. It uses a start/busy/done handshake toward the controlling logic.

Parameters:
DATA_WIDTH, 8, number of bits per transfer (>= 2).
BIT_PERIOD, 4, clock cycles per bit (>= 3).
MSB_FIRST, 0, 0 = bit 0 sent first; 1 = bit DATA_WIDTH-1 sent first.

Ports:
clock  input  1  single system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a transfer; sampled only in IDLE.
parallelIn  input  DATA_WIDTH  word to send; captured on the accepted start.
busy  output  1  high from the cycle after start is accepted through the DONE cycle.
done  output  1  one-cycle pulse after the last bit's hold phase.
data  output  1  current serial bit.
notdata  output  1  always ~data.
enable  output  1  latch strobe; high only in strobe phases.
bitIndex  output  clog2(DATA_WIDTH)  index of the bit currently on `data`; 0 when idle.

Behaviour:
- Interface: one clock, `clock`; reset is synchronous and active-high, port `reset`.
- All outputs are registered.
- Reset values: busy=0, done=0, data=0, notdata=1, enable=0, bitIndex=0. State returns to IDLE.
- Reset mid-transfer aborts the transfer at the next edge, with no done pulse. The captured word is discarded.
- States and transitions:
  - IDLE: outputs at reset values. If start=1, capture parallelIn into a shift register and go to SEND with phase=0 and bit=0.
  - SEND: a phase counter runs 0..BIT_PERIOD-1.
    - phase 0 (setup): data = current bit, enable=0.
    - phases 1..BIT_PERIOD-2 (strobe): enable=1, data stable.
    - phase BIT_PERIOD-1 (hold): enable=0, data stable.
    - At the end of the hold phase, advance to the next bit with phase=0. After the last bit, go to DONE.
  - DONE: done=1, busy=1, enable=0, data holds the last bit. Next state is IDLE with data=0.
- Bit order: MSB_FIRST=0 sends parallelIn[0] first. MSB_FIRST=1 sends parallelIn[DATA_WIDTH-1] first.
- bitIndex reports the logical position of the bit in parallelIn, not the send count.
- Timing, with start accepted at edge k:
  - busy=1 and data=first bit from k+1.
  - First enable high from k+2.
  - done high during cycle k+1+DATA_WIDTH*BIT_PERIOD.
  - busy is high for DATA_WIDTH*BIT_PERIOD+1 cycles (33 at defaults).
- data changes only in setup phases or on DONE→IDLE, never while enable=1 and never in the cycle enable falls.
- enable is high for exactly BIT_PERIOD-2 consecutive cycles per bit (2 at defaults), DATA_WIDTH pulses per transfer.
- start while busy=1, including in DONE, is ignored. parallelIn changes after capture have no effect.
- start held high continuously produces back-to-back transfers separated by exactly one IDLE cycle.
- start and reset high together: reset wins.

Test Plan:
- Reset then idle 5 cycles → busy=0, done=0, data=0, notdata=1, enable=0, bitIndex=0 throughout.
- Defaults, parallelIn=8'hA5, 1-cycle start → data per bit = 1,0,1,0,0,1,0,1. Exactly 8 enable pulses, each 2 cycles wide. done at cycle 33 after the start edge. A behavioural gated D latch on data/enable holds 1 after the final strobe. Concatenated captures equal 8'hA5.
- MSB_FIRST=1, parallelIn=8'h81, BIT_PERIOD=3 → bit sequence 1,0,0,0,0,0,0,1 with 1-cycle enables. bitIndex goes 7 down to 0. done at cycle 25.
- start pulsed at transfer cycles 5 and 20, with parallelIn changed to 8'hFF at the same time → no restart, sent word unchanged, single done pulse.
- reset asserted in strobe phase of bit 3 → next cycle all outputs at reset values, no done. A new start with 8'h3C then completes correctly.
- Checker over all runs: data never changes while enable=1 or in the cycle enable deasserts; notdata == ~data every cycle.
